// File: rtl/tile_noc_rx.sv
// tile_noc_rx: mesh ejection endpoint reassembling head+body flits into queued messages
module tile_noc_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int N_BODY     = 4,
    parameter int DEPTH      = 4,
    parameter int TILE_ID_W  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_flit,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [TILE_ID_W-1:0]             out_src,
    output logic [N_BODY*(DATA_WIDTH-1)-1:0] out_data,
    output logic [15:0]                      msg_count,
    output logic [15:0]                      err_count
);
    localparam int PW = DATA_WIDTH - 1;
    localparam int MW = N_BODY * PW;
    localparam int AW = $clog2(DEPTH);
    localparam int BW = (N_BODY > 1) ? $clog2(N_BODY) : 1;
    localparam logic [BW-1:0] LAST = BW'(N_BODY - 1);

    typedef enum logic {IDLE, BODY} state_t;

    state_t                      state, state_n;
    logic [BW-1:0]               beat_cnt;
    logic [TILE_ID_W-1:0]        src_q;
    logic [MW-1:0]               stage_q, stage_n;
    logic [TILE_ID_W+MW-1:0]     mem [DEPTH];
    logic [AW:0]                 wr_ptr, rd_ptr;
    logic                        acc, head, last, full, push, pop, err;

    // Framing decode, FIFO status, next state and staging merge of the incoming flit
    always_comb begin
        acc       = in_valid & in_ready;
        head      = in_flit[DATA_WIDTH-1];
        last      = (state == BODY) && (beat_cnt == LAST);
        full      = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
        in_ready  = !(last && full);
        push      = acc && !head && last;
        err       = acc && (head ? (state == BODY) : (state == IDLE));
        out_valid = wr_ptr != rd_ptr;
        pop       = out_valid && out_ready;
        {out_src, out_data} = mem[rd_ptr[AW-1:0]];
        stage_n   = stage_q;
        stage_n[beat_cnt*PW +: PW] = in_flit[PW-1:0];
        state_n   = state;
        if (acc) state_n = head ? BODY : (last ? IDLE : state);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Packet staging, message FIFO and statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            src_q     <= '0;
            stage_q   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            msg_count <= '0;
            err_count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (acc && head) begin
                src_q    <= in_flit[TILE_ID_W-1:0];
                beat_cnt <= '0;
            end else if (acc && state == BODY) begin
                stage_q  <= stage_n;
                beat_cnt <= last ? '0 : beat_cnt + 1'b1;
            end
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {src_q, stage_n};
                wr_ptr    <= wr_ptr + 1'b1;
                msg_count <= msg_count + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (err && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_tile_noc_rx.sv
// tb_tile_noc_rx: scenario tasks plus randomized packet stream against a message-queue model
module tb_tile_noc_rx;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_flit = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [3:0]   out_src;
    logic [123:0] out_data;
    logic [15:0]  msg_count, err_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]   src;
        logic [123:0] data;
    } msg_t;
    msg_t exp_q[$];

    always #5 clk = ~clk;

    tile_noc_rx dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_data(out_data),
        .msg_count(msg_count), .err_count(err_count)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] hd(input logic [3:0] s);
        return {1'b1, 27'h0, s};
    endfunction

    function automatic logic [31:0] bd(input logic [30:0] p);
        return {1'b0, p};
    endfunction

    function automatic logic [123:0] mk(input int b);
        logic [123:0] d;
        for (int k = 0; k < 4; k++) d[k*31 +: 31] = 31'(b + k);
        return d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_flit = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the flit was accepted.
    task automatic send(input logic [31:0] f);
        int n = 0;
        in_valid = 1'b1; in_flit = f;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stuck low, flit %h", f);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] s, input logic [123:0] d);
        send(hd(s));
        for (int k = 0; k < 4; k++) send(bd(d[k*31 +: 31]));
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        tests++; if (msg_count !== 16'd0 || err_count !== 16'd0) begin fails++; $display("FAIL rst_counts: got %0d/%0d want 0/0", msg_count, err_count); end
        tests++; if (out_src !== 4'd0 || out_data !== 124'd0) begin fails++; $display("FAIL rst_outputs: got src %h data %h want 0", out_src, out_data); end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        send(hd(4'd3));
        for (int k = 1; k <= 3; k++) send(bd(31'(k)));
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early: out_valid got %b want 0", out_valid); end
        send(bd(31'd4));
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: out_valid got %b want 1", out_valid); end
        tests++; if (out_src !== 4'd3) begin fails++; $display("FAIL basic_src: got %h want 3", out_src); end
        tests++; if (out_data !== mk(1)) begin fails++; $display("FAIL basic_data: got %h want %h", out_data, mk(1)); end
        tests++; if (msg_count !== 16'd1) begin fails++; $display("FAIL basic_msg_count: got %0d want 1", msg_count); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_pop: out_valid got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_fifo();
        do_reset();
        for (int i = 0; i < 4; i++) send_pkt(4'(i + 1), mk(i * 4));
        send(hd(4'd5));
        for (int k = 0; k < 3; k++) send(bd(31'(16 + k)));
        in_valid = 1'b1; in_flit = bd(31'd19);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        tests++; if (msg_count !== 16'd4) begin fails++; $display("FAIL full_msg_count: got %0d want 4", msg_count); end
        @(negedge clk);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_hold: in_ready got %b want 0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_freed: in_ready got %b want 1", in_ready); end
        tests++; if (out_src !== 4'd2) begin fails++; $display("FAIL full_next_src: got %h want 2", out_src); end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (msg_count !== 16'd5) begin fails++; $display("FAIL full_commit5: got %0d want 5", msg_count); end
        for (int i = 1; i < 5; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_src !== 4'(i + 1) || out_data !== mk(i * 4)) begin
                fails++;
                $display("FAIL full_drain%0d: got v%b src %h data %h want v1 src %h data %h", i, out_valid, out_src, out_data, 4'(i + 1), mk(i * 4));
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_empty: out_valid got %b want 0", out_valid); end
        tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL full_err: got %0d want 0", err_count); end
    endtask

    task automatic test_idle_body();
        do_reset();
        send(bd(31'd7));
        tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL idle_err: got %0d want 1", err_count); end
        tests++; if (out_valid !== 1'b0 || msg_count !== 16'd0) begin fails++; $display("FAIL idle_msg: got v%b cnt %0d want v0 cnt 0", out_valid, msg_count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_restart();
        do_reset();
        out_ready = 1'b0;
        send(hd(4'd2));
        send(bd(31'd1));
        send(bd(31'd2));
        send_pkt(4'd5, mk(10));
        tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL restart_err: got %0d want 1", err_count); end
        tests++; if (msg_count !== 16'd1) begin fails++; $display("FAIL restart_msg: got %0d want 1", msg_count); end
        tests++; if (out_src !== 4'd5 || out_data !== mk(10)) begin fails++; $display("FAIL restart_data: got src %h data %h want src 5 data %h", out_src, out_data, mk(10)); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL restart_single: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_pkt(4'd1, mk(40));
        send_pkt(4'd2, mk(50));
        send(hd(4'd7));
        send(bd(31'd1));
        send(bd(31'd2));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        tests++; if (msg_count !== 16'd0 || err_count !== 16'd0) begin fails++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", msg_count, err_count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        send_pkt(4'd9, mk(100));
        tests++; if (out_valid !== 1'b1 || out_src !== 4'd9 || out_data !== mk(100)) begin fails++; $display("FAIL midrst_after: got v%b src %h data %h want v1 src 9 data %h", out_valid, out_src, out_data, mk(100)); end
        tests++; if (msg_count !== 16'd1 || err_count !== 16'd0) begin fails++; $display("FAIL midrst_after_counts: got %0d/%0d want 1/0", msg_count, err_count); end
    endtask

    task automatic test_random();
        int got = 0;
        int cyc = 0;
        do_reset();
        exp_q.delete();
        fork
            begin
                for (int p = 0; p < 1000; p++) begin
                    msg_t m;
                    m.src = 4'($urandom);
                    for (int k = 0; k < 4; k++) m.data[k*31 +: 31] = 31'($urandom);
                    exp_q.push_back(m);
                    for (int k = 0; k < 5; k++) begin
                        int g = $urandom_range(0, 3);
                        if (g > 1) repeat (g - 1) begin
                            in_flit = $urandom;
                            @(negedge clk);
                        end
                        send(k == 0 ? hd(m.src) : bd(m.data[(k-1)*31 +: 31]));
                    end
                end
            end
            begin
                while (got < 1000 && cyc < 60000) begin
                    logic r;
                    r = 1'($urandom);
                    out_ready = r;
                    if (out_valid && r) begin
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL rand_extra: unexpected message src %h data %h", out_src, out_data);
                        end else begin
                            msg_t m = exp_q.pop_front();
                            if (out_src !== m.src || out_data !== m.data) begin
                                fails++;
                                $display("FAIL rand_msg%0d: got src %h data %h want src %h data %h", got, out_src, out_data, m.src, m.data);
                            end
                        end
                        got++;
                    end
                    @(negedge clk);
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        tests++; if (got !== 1000) begin fails++; $display("FAIL rand_received: got %0d want 1000", got); end
        tests++; if (msg_count !== 16'd1000) begin fails++; $display("FAIL rand_msg_count: got %0d want 1000", msg_count); end
        tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL rand_err_count: got %0d want 0", err_count); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rand_leftover: got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_fifo();
        test_idle_body();
        test_restart();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
